pong_engine: RTL

- Parametrised game core for the VGA Pong display. Replaces the fixed-position image generator.
- Holds ball and paddle state, moves them once per video frame, bounces the ball off walls and paddles, keeps score, and runs a serve/point/game-over state machine.
- Sits between the VGA timing block, which supplies x, y and frame_tick, and the RGB output pins.

---
 rtl/pong_engine_if.sv | 33 +++
 rtl/pong_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine_if.sv
// ============================================================================
// Module   : pong_engine_if
// Brief    : Pixel-position, controller and display bundle for pong_engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pong_engine_if;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_tick;
  logic        p1_up;
  logic        p1_down;
  logic        p2_up;
  logic        p2_down;
  logic        serve;
  logic [2:0]  color;
  logic [3:0]  score_p1;
  logic [3:0]  score_p2;
  logic        game_over;

  modport master (
    output x, y, frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
    input  color, score_p1, score_p2, game_over
  );

  modport slave (
    input  x, y, frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
    output color, score_p1, score_p2, game_over
  );
endinterface

`default_nettype wire

// File: rtl/pong_engine.sv
// ============================================================================
// Module   : pong_engine
// Brief    : Pong game core: frame-rate ball/paddle motion, scoring, serve FSM
//            and per-pixel colour. Define PONG_ANGLE_EN for hit-zone angles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_engine #(
  parameter int FRAME_W      = 640,
  parameter int FRAME_H      = 480,
  parameter int BALL_SIZE    = 10,
  parameter int PADDLE_W     = 12,
  parameter int PADDLE_H     = 60,
  parameter int P1_X         = 24,
  parameter int P2_X         = 604,
  parameter int PADDLE_SPEED = 6,
  parameter int BALL_DX      = 4,
  parameter int BALL_DY      = 2,
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic          CLOCK_25,
  input  logic          RESET_N,
  pong_engine_if.slave  bus
);

  localparam int          c_cnt_w      = $clog2(PAUSE_FRAMES + 1);
  localparam logic [11:0] c_ball_size  = 12'(BALL_SIZE);
  localparam logic [11:0] c_paddle_w   = 12'(PADDLE_W);
  localparam logic [11:0] c_paddle_h   = 12'(PADDLE_H);
  localparam logic [11:0] c_p1_x       = 12'(P1_X);
  localparam logic [11:0] c_p2_x       = 12'(P2_X);
  localparam logic [11:0] c_pspeed     = 12'(PADDLE_SPEED);
  localparam logic [11:0] c_dx         = 12'(BALL_DX);
  localparam logic [11:0] c_dy         = 12'(BALL_DY);
  localparam logic [11:0] c_ball_x0    = 12'((FRAME_W - BALL_SIZE) / 2);
  localparam logic [11:0] c_ball_y0    = 12'((FRAME_H - BALL_SIZE) / 2);
  localparam logic [11:0] c_paddle_y0  = 12'((FRAME_H - PADDLE_H) / 2);
  localparam logic [11:0] c_ball_x_max = 12'(FRAME_W - BALL_SIZE);
  localparam logic [11:0] c_ball_y_max = 12'(FRAME_H - BALL_SIZE);
  localparam logic [11:0] c_paddle_max = 12'(FRAME_H - PADDLE_H);
  localparam logic [11:0] c_p1_face    = 12'(P1_X + PADDLE_W);
  localparam logic [11:0] c_p2_face    = 12'(P2_X - BALL_SIZE);
  localparam logic [3:0]  c_win        = 4'(WIN_SCORE);
  localparam logic [c_cnt_w-1:0] c_pause_last = c_cnt_w'(PAUSE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [11:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [11:0]        p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic [11:0]        dy_q, dy_d;
  logic               dir_left_q, dir_left_d, dir_up_q, dir_up_d;
  logic [3:0]         score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  logic [11:0]        w_by;
  logic [11:0]        w_paddle_y;
  logic               w_overlap;
  logic               w_point;
  logic               w_p1_scores;

  function automatic logic [11:0] paddle_next(input logic [11:0] py,
                                              input logic up, input logic dn);
    paddle_next = py;
    if (up && !dn)
      paddle_next = (py < c_pspeed) ? 12'd0 : py - c_pspeed;
    else if (dn && !up)
      paddle_next = (py + c_pspeed > c_paddle_max) ? c_paddle_max : py + c_pspeed;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    sat_inc = (s == 4'd15) ? s : s + 4'd1;
  endfunction

`ifdef PONG_ANGLE_EN
  localparam logic [11:0] c_half_ball = 12'(BALL_SIZE / 2);
  localparam logic [11:0] c_band1     = 12'(PADDLE_H / 4);
  localparam logic [11:0] c_band2     = 12'(PADDLE_H / 2);
  localparam logic [11:0] c_band3     = 12'((3 * PADDLE_H) / 4);

  // {dir_up, dy} from where the ball centre struck the paddle face.
  function automatic logic [12:0] hit_angle(input logic [11:0] by, input logic [11:0] py);
    logic [11:0] centre;
    logic [11:0] d;
    centre = by + c_half_ball;
    d      = (centre < py) ? 12'd0 : centre - py;
    if (d > c_paddle_h - 12'd1) d = c_paddle_h - 12'd1;
    hit_angle[12]   = (d < c_band2);
    hit_angle[11:0] = (d < c_band1 || d >= c_band3) ? c_dy + 12'd2 : c_dy;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    p1_y_d      = p1_y_q;
    p2_y_d      = p2_y_q;
    dy_d        = dy_q;
    dir_left_d  = dir_left_q;
    dir_up_d    = dir_up_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    cnt_d       = cnt_q;
    w_by        = ball_y_q;
    w_paddle_y  = dir_left_q ? p1_y_q : p2_y_q;
    w_overlap   = 1'b0;
    w_point     = 1'b0;
    w_p1_scores = 1'b0;

    if (bus.frame_tick) begin
      if (state_q != ST_OVER) begin
        p1_y_d = paddle_next(p1_y_q, bus.p1_up, bus.p1_down);
        p2_y_d = paddle_next(p2_y_q, bus.p2_up, bus.p2_down);
      end

      unique case (state_q)
        ST_SERVE: if (bus.serve) state_d = ST_PLAY;

        ST_PLAY: begin
          if (dir_up_q) begin
            if (ball_y_q < dy_q) begin
              w_by     = 12'd0;
              dir_up_d = 1'b0;
            end else begin
              w_by = ball_y_q - dy_q;
            end
          end else if (ball_y_q + dy_q > c_ball_y_max) begin
            w_by     = c_ball_y_max;
            dir_up_d = 1'b1;
          end else begin
            w_by = ball_y_q + dy_q;
          end
          ball_y_d  = w_by;
          // Overlap pairs the moved ball with the paddle as it stood last frame.
          w_overlap = (w_by + c_ball_size > w_paddle_y) && (w_by < w_paddle_y + c_paddle_h);

          if (dir_left_q) begin
            if (ball_x_q <= c_p1_face - 12'd1 + c_dx && ball_x_q >= c_p1_face && w_overlap) begin
              ball_x_d   = c_p1_face;
              dir_left_d = 1'b0;
`ifdef PONG_ANGLE_EN
              {dir_up_d, dy_d} = hit_angle(w_by, w_paddle_y);
`endif
            end else if (ball_x_q < c_dx) begin
              w_point = 1'b1;
            end else begin
              ball_x_d = ball_x_q - c_dx;
            end
          end else begin
            if (ball_x_q + c_dx >= c_p2_face + 12'd1 && ball_x_q <= c_p2_face && w_overlap) begin
              ball_x_d   = c_p2_face;
              dir_left_d = 1'b1;
`ifdef PONG_ANGLE_EN
              {dir_up_d, dy_d} = hit_angle(w_by, w_paddle_y);
`endif
            end else if (ball_x_q + c_dx > c_ball_x_max) begin
              w_point     = 1'b1;
              w_p1_scores = 1'b1;
            end else begin
              ball_x_d = ball_x_q + c_dx;
            end
          end

          if (w_point) begin
            if (w_p1_scores) score_p1_d = sat_inc(score_p1_q);
            else             score_p2_d = sat_inc(score_p2_q);
            ball_x_d   = c_ball_x0;
            ball_y_d   = c_ball_y0;
            dy_d       = c_dy;
            dir_left_d = w_p1_scores;
            cnt_d      = '0;
            state_d    = ST_POINT;
          end
        end

        ST_POINT: begin
          if (cnt_q == c_pause_last) begin
            cnt_d   = '0;
            state_d = (score_p1_q == c_win || score_p2_q == c_win) ? ST_OVER : ST_SERVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_OVER: begin
          if (bus.serve) begin
            score_p1_d = 4'd0;
            score_p2_d = 4'd0;
            state_d    = ST_SERVE;
          end
        end

        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      state_q    <= ST_SERVE;
      ball_x_q   <= c_ball_x0;
      ball_y_q   <= c_ball_y0;
      p1_y_q     <= c_paddle_y0;
      p2_y_q     <= c_paddle_y0;
      dy_q       <= c_dy;
      dir_left_q <= 1'b0;
      dir_up_q   <= 1'b0;
      score_p1_q <= 4'd0;
      score_p2_q <= 4'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      p1_y_q     <= p1_y_d;
      p2_y_q     <= p2_y_d;
      dy_q       <= dy_d;
      dir_left_q <= dir_left_d;
      dir_up_q   <= dir_up_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      cnt_q      <= cnt_d;
    end
  end

  logic w_in_ball, w_in_p1, w_in_p2;

  always_comb begin
    w_in_ball = (bus.x >= ball_x_q) && (bus.x <= ball_x_q + c_ball_size - 12'd1) &&
                (bus.y >= ball_y_q) && (bus.y <= ball_y_q + c_ball_size - 12'd1);
    w_in_p1   = (bus.x >= c_p1_x) && (bus.x <= c_p1_x + c_paddle_w - 12'd1) &&
                (bus.y >= p1_y_q) && (bus.y <= p1_y_q + c_paddle_h - 12'd1);
    w_in_p2   = (bus.x >= c_p2_x) && (bus.x <= c_p2_x + c_paddle_w - 12'd1) &&
                (bus.y >= p2_y_q) && (bus.y <= p2_y_q + c_paddle_h - 12'd1);
    if (w_in_ball)    bus.color = 3'b111;
    else if (w_in_p1) bus.color = 3'b001;
    else if (w_in_p2) bus.color = 3'b100;
    else              bus.color = 3'b000;
  end

  assign bus.score_p1  = score_p1_q;
  assign bus.score_p2  = score_p2_q;
  assign bus.game_over = (state_q == ST_OVER);

endmodule

`default_nettype wire
